ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
Parametrised fetch/decode/execute control unit for the 16-bit accumulator-less RF processor. It adds JMP, BRZ and LDI instructions, data-memory wait states, and an illegal-opcode policy. It holds the PC and IR and drives the external synchronous instruction ROM (1-cycle read latency), the data memory, the register file and the ALU. It sits between the instruction ROM and the datapath.

Parameters:
PC_W, 7, PC / instruction-address width (1..12).
START_ADDR, 0, PC value loaded on reset (truncated to PC_W).
HALT_ON_ILLEGAL, 1, 1: opcodes 1001-1111 go to HALT; 0: executed as NOOP.

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  asynchronous active-high reset
I_Data  in  16  instruction ROM output (valid one cycle after I_Addr is registered by the ROM)
D_Ready  in  1  data memory ready; LOAD_A/STORE hold while 0
Ra_Zero  in  1  datapath flag: RF[RF_Ra_Addr]==0
I_Addr  out  PC_W  instruction address (= PC_Out)
PC_Out  out  PC_W  program counter
IR_Out  out  16  instruction register
OutState  out  4  current state code
NextState  out  4  combinational next state
D_Addr  out  8  data memory address
D_Rd  out  1  data memory read strobe
D_Wr  out  1  data memory write strobe
RF_s  out  2  RF write source: 00 ALU, 01 data memory, 10 immediate
RF_W_en  out  1  RF write enable
RF_W_Addr  out  4  RF write address
RF_Ra_Addr  out  4  RF port A address
RF_Rb_Addr  out  4  RF port B address
Alu_s0  out  3  ALU op: 000 pass A, 001 A+B, 010 A-B
Imm  out  8  immediate, zero-extended by datapath
Halted  out  1  1 while in HALT

Behaviour:
- Rst=1 (async): state=INIT, PC=START_ADDR, IR=0. All outputs not listed per state below are 0.
- State codes: INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9, LDI 10, JMP 11, BRZ 12, REFILL 13.
- INIT->REFILL. REFILL->FETCH. REFILL is a 1-cycle bubble so the ROM output matches the current PC.
- FETCH: IR<=I_Data; PC<=PC+1 mod 2^PC_W. Next state is DECODE.
- DECODE: dispatch on IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD_A, 0011 ADD, 0100 SUB, 0101 HALT, 0110 LDI, 0111 JMP, 1000 BRZ. 1001-1111 go to HALT if HALT_ON_ILLEGAL=1, else NOOP.
- NOOP, LOAD_B, ADD, SUB, LDI -> FETCH. No bubble is needed: the PC has been stable for at least 2 cycles.
- STORE: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], D_Wr=1. Stay in STORE while D_Ready=0; go to FETCH when D_Ready=1.
- LOAD_A: D_Addr=IR[7:0], D_Rd=1. Stay while D_Ready=0; go to LOAD_B when D_Ready=1.
- LOAD_B: D_Addr=IR[7:0], RF_s=01, RF_W_Addr=IR[11:8], RF_W_en=1.
- ADD/SUB: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_W_en=1, RF_s=00, Alu_s0=001 (ADD) or 010 (SUB).
- LDI: Imm=IR[7:0], RF_s=10, RF_W_Addr=IR[11:8], RF_W_en=1.
- JMP: PC<=IR[PC_W-1:0]. Next state is REFILL.
- BRZ: RF_Ra_Addr=IR[11:8]; Ra_Zero is sampled in this state.
  - Ra_Zero=1: PC<=PC+sext(IR[7:0]) mod 2^PC_W, where PC is already the branch address+1. Next state is REFILL.
  - Ra_Zero=0: PC unchanged. Next state is FETCH.
- HALT: Halted=1. State and PC frozen until Rst.
- Outputs are Moore: a function of the state and IR only. NextState is combinational from state, IR, D_Ready and Ra_Zero.
- Rst asserted mid-instruction aborts immediately; no write strobe may stay asserted after Rst rises.

Test Plan:
- Reset/fetch: Rst=1 for 3 cycles, then release; ROM[0]=16'h0000. Required: state sequence 0,13,1,2,3,1; PC 0->1 at the FETCH edge; IR=16'h0000.
- LOAD with wait, ROM[0]=16'h2312, D_Ready=0 for 3 cycles: LOAD_A held 4 cycles with D_Rd=1 and D_Addr=8'h12. Then LOAD_B with RF_s=01, RF_W_Addr=3, RF_W_en=1 for exactly 1 cycle.
- ADD 16'h3125: RF_Ra_Addr=1, RF_Rb_Addr=2, RF_W_Addr=5, Alu_s0=001, RF_W_en=1 for 1 cycle. SUB 16'h4125 is identical except Alu_s0=010.
- Branch at PC=5, IR=16'h82FE (offset -2):
  - Ra_Zero=1: PC 6->4, then REFILL, then FETCH loads ROM[4].
  - Ra_Zero=0: PC stays 6 and the next state is FETCH.
- JMP/wrap with PC_W=7: JMP 16'h707F gives PC=127; FETCH at 127 wraps PC to 0. LDI 16'h6AC3 gives Imm=8'hC3, RF_W_Addr=10, RF_s=10.
- Illegal/halt: IR=16'hF000 with HALT_ON_ILLEGAL=1 gives state 9, Halted=1, PC frozen for 10 cycles. With HALT_ON_ILLEGAL=0 it executes as NOOP. Rst mid-STORE drops D_Wr at once and returns to INIT with PC=START_ADDR.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: fetch/decode/execute control unit for the 16-bit RF processor.
// Holds PC and IR, drives a synchronous instruction ROM (1-cycle read latency),
// the data memory (with wait states), the register file and the ALU.
// Control outputs are Moore outputs registered from the next state and next IR,
// so they change together with OutState and clear as soon as Rst rises.
module ctrl_sequencer #(
    parameter int unsigned PC_W            = 7,
    parameter int unsigned START_ADDR      = 0,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [15:0]     I_Data,
    input  logic            D_Ready,
    input  logic            Ra_Zero,
    output logic [PC_W-1:0] I_Addr,
    output logic [PC_W-1:0] PC_Out,
    output logic [15:0]     IR_Out,
    output logic [3:0]      OutState,
    output logic [3:0]      NextState,
    output logic [7:0]      D_Addr,
    output logic            D_Rd,
    output logic            D_Wr,
    output logic [1:0]      RF_s,
    output logic            RF_W_en,
    output logic [3:0]      RF_W_Addr,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic [2:0]      Alu_s0,
    output logic [7:0]      Imm,
    output logic            Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9,
        S_LDI    = 4'd10,
        S_JMP    = 4'd11,
        S_BRZ    = 4'd12,
        S_REFILL = 4'd13
    } state_t;

    typedef struct packed {
        logic [7:0] d_addr;
        logic       d_rd;
        logic       d_wr;
        logic [1:0] rf_s;
        logic       rf_w_en;
        logic [3:0] rf_w_addr;
        logic [3:0] rf_ra_addr;
        logic [3:0] rf_rb_addr;
        logic [2:0] alu_s0;
        logic [7:0] imm;
        logic       halted;
    } ctrl_t;

    localparam logic [PC_W-1:0] START_PC  = PC_W'(START_ADDR);
    localparam ctrl_t           CTRL_IDLE = '0;

    state_t          state_r;
    state_t          next_state_s;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     ir_r;
    logic [15:0]     next_ir_s;
    ctrl_t           ctrl_r;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] br_off_s;
    logic [PC_W-1:0] br_tgt_s;

    // Opcode dispatch out of DECODE; unassigned opcodes follow the illegal policy.
    function automatic state_t dispatch(input logic [3:0] opc);
        state_t st;
        case (opc)
            4'h0:    st = S_NOOP;
            4'h1:    st = S_STORE;
            4'h2:    st = S_LOAD_A;
            4'h3:    st = S_ADD;
            4'h4:    st = S_SUB;
            4'h5:    st = S_HALT;
            4'h6:    st = S_LDI;
            4'h7:    st = S_JMP;
            4'h8:    st = S_BRZ;
            default: st = HALT_ON_ILLEGAL ? S_HALT : S_NOOP;
        endcase
        return st;
    endfunction

    // Moore control word for a given state and instruction register.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            S_LOAD_A: begin
                c.d_addr = ir[7:0];
                c.d_rd   = 1'b1;
            end
            S_LOAD_B: begin
                c.d_addr    = ir[7:0];
                c.rf_s      = 2'b01;
                c.rf_w_addr = ir[11:8];
                c.rf_w_en   = 1'b1;
            end
            S_STORE: begin
                c.d_addr     = ir[7:0];
                c.rf_ra_addr = ir[11:8];
                c.d_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                c.rf_ra_addr = ir[11:8];
                c.rf_rb_addr = ir[7:4];
                c.rf_w_addr  = ir[3:0];
                c.rf_w_en    = 1'b1;
                c.rf_s       = 2'b00;
                c.alu_s0     = (st == S_ADD) ? 3'b001 : 3'b010;
            end
            S_LDI: begin
                c.imm       = ir[7:0];
                c.rf_s      = 2'b10;
                c.rf_w_addr = ir[11:8];
                c.rf_w_en   = 1'b1;
            end
            S_BRZ: begin
                c.rf_ra_addr = ir[11:8];
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = CTRL_IDLE;
            end
        endcase
        return c;
    endfunction

    // PC arithmetic: sequential increment and sign-extended relative branch, both modulo 2^PC_W.
    assign pc_inc_s = pc_r + PC_W'(1'b1);
    assign br_off_s = PC_W'($signed(ir_r[7:0]));
    assign br_tgt_s = pc_r + br_off_s;

    // Next-state logic; unused encodings fall back to INIT.
    always_comb begin
        next_state_s = S_INIT;
        case (state_r)
            S_INIT:   next_state_s = S_REFILL;
            S_REFILL: next_state_s = S_FETCH;
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: next_state_s = dispatch(ir_r[15:12]);
            S_NOOP, S_LOAD_B, S_ADD, S_SUB, S_LDI: next_state_s = S_FETCH;
            S_STORE: begin
                if (D_Ready) next_state_s = S_FETCH;
                else         next_state_s = S_STORE;
            end
            S_LOAD_A: begin
                if (D_Ready) next_state_s = S_LOAD_B;
                else         next_state_s = S_LOAD_A;
            end
            S_JMP: next_state_s = S_REFILL;
            S_BRZ: begin
                if (Ra_Zero) next_state_s = S_REFILL;
                else         next_state_s = S_FETCH;
            end
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_INIT;
        endcase
    end

    // IR captures the ROM word only in FETCH; registered outputs are decoded from it.
    always_comb begin
        if (state_r == S_FETCH) next_ir_s = I_Data;
        else                    next_ir_s = ir_r;
    end

    // Sequencer state, PC, IR and registered control outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= S_INIT;
            pc_r    <= START_PC;
            ir_r    <= 16'h0000;
            ctrl_r  <= CTRL_IDLE;
        end else begin
            state_r <= next_state_s;
            ir_r    <= next_ir_s;
            ctrl_r  <= ctrl_for(next_state_s, next_ir_s);
            case (state_r)
                S_FETCH: pc_r <= pc_inc_s;
                S_JMP:   pc_r <= ir_r[PC_W-1:0];
                S_BRZ: begin
                    if (Ra_Zero) pc_r <= br_tgt_s;
                    else         pc_r <= pc_r;
                end
                default: pc_r <= pc_r;
            endcase
        end
    end

    assign I_Addr     = pc_r;
    assign PC_Out     = pc_r;
    assign IR_Out     = ir_r;
    assign OutState   = state_r;
    assign NextState  = next_state_s;
    assign D_Addr     = ctrl_r.d_addr;
    assign D_Rd       = ctrl_r.d_rd;
    assign D_Wr       = ctrl_r.d_wr;
    assign RF_s       = ctrl_r.rf_s;
    assign RF_W_en    = ctrl_r.rf_w_en;
    assign RF_W_Addr  = ctrl_r.rf_w_addr;
    assign RF_Ra_Addr = ctrl_r.rf_ra_addr;
    assign RF_Rb_Addr = ctrl_r.rf_rb_addr;
    assign Alu_s0     = ctrl_r.alu_s0;
    assign Imm        = ctrl_r.imm;
    assign Halted     = ctrl_r.halted;

endmodule
